// File: rtl/ff_div_n.sv
// ---------------------------------------------------------------------------
// ff_div_n -- programmable sample-and-hold rate divider.
//
// After a load request the block captures the input word `s` once every P
// clock cycles and holds it on `q` in between. P is latched from `div` on
// each accepted load and clamped into 1..DIV_MAX. Every capture raises
// `q_valid` for exactly the cycle after the capture edge.
//
// Ports:
//   aclk     in   1      clock, all logic on its rising edge
//   areset   in   1      synchronous active-high reset
//   ld       in   1      start / restart request, latches `div`
//   stop     in   1      return to IDLE, keeping the last `q`
//   div      in   CNT_W  requested hold period P (sampled only with `ld`)
//   s        in   WIDTH  data to sample
//   q        out  WIDTH  held sample (registered)
//   q_valid  out  1      one-cycle strobe after each capture edge
//   busy     out  1      high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module ff_div_n #(
    parameter int WIDTH   = 32,
    parameter int DIV_MAX = 16,
    parameter int CNT_W   = $clog2(DIV_MAX + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             ld,
    input  logic             stop,
    input  logic [CNT_W-1:0] div,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_TWO     = C_ONE + C_ONE;
    localparam logic [CNT_W-1:0] C_DIV_MAX = CNT_W'(DIV_MAX);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_busy;

    // Map a requested period into the supported range: 0 means "every
    // cycle" and anything above DIV_MAX saturates.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] res;
        if (d == C_ZERO) begin
            res = C_ONE;
        end else if (d > C_DIV_MAX) begin
            res = C_DIV_MAX;
        end else begin
            res = d;
        end
        return res;
    endfunction

    // Single FSM: state, hold counter, latched ratio and all registered outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= C_ZERO;
            r_div     <= C_ONE;
            r_q       <= {WIDTH{1'b0}};
            r_q_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // The strobe is a single-cycle pulse unless a capture sets it below.
            r_q_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ld && !stop) begin
                        r_div   <= clamp_div(div);
                        r_state <= ST_SAMPLE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_SAMPLE: begin
                    // stop beats ld, and both suppress the capture on this edge.
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (ld) begin
                        r_div   <= clamp_div(div);
                        r_state <= ST_SAMPLE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_q       <= s;
                        r_q_valid <= 1'b1;
                        r_cnt     <= r_div - C_ONE;
                        r_busy    <= 1'b1;
                        // With P = 1 there is no hold phase: capture again next edge.
                        if (r_div >= C_TWO) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_SAMPLE;
                        end
                    end
                end

                ST_HOLD: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (ld) begin
                        r_div   <= clamp_div(div);
                        r_state <= ST_SAMPLE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt - C_ONE;
                        r_busy <= 1'b1;
                        // A zero count cannot occur normally; treating it like
                        // the last hold cycle keeps the FSM from wrapping.
                        if ((r_cnt == C_ONE) || (r_cnt == C_ZERO)) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign busy    = r_busy;

endmodule

// File: tb/tb_ff_div_n.sv
// ---------------------------------------------------------------------------
// tb_ff_div_n -- self-checking bench for ff_div_n.
// A time-based reference (running flag, period, edge number of the next
// capture) predicts q / q_valid / busy; a negedge process compares every
// cycle, and directed scenarios pin literal values.
// ---------------------------------------------------------------------------
module tb_ff_div_n;

    localparam int WIDTH   = 32;
    localparam int DIV_MAX = 16;
    localparam int CNT_W   = $clog2(DIV_MAX + 1);

    logic             aclk = 1'b0;
    logic             areset = 1'b0;
    logic             ld = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] div = '0;
    logic [WIDTH-1:0] s = '0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             busy;

    ff_div_n #(.WIDTH(WIDTH), .DIV_MAX(DIV_MAX)) dut (
        .aclk(aclk), .areset(areset), .ld(ld), .stop(stop),
        .div(div), .s(s), .q(q), .q_valid(q_valid), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int          ecnt   = 0;
    bit          m_run  = 1'b0;
    int          m_p    = 1;
    int          m_next = 0;
    logic [31:0] m_q    = '0;
    bit          m_qv   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    function automatic int clamp(input int d);
        if (d == 0) return 1;
        if (d > DIV_MAX) return DIV_MAX;
        return d;
    endfunction

    task automatic model_edge(input bit rst, input bit l, input bit st, input int d, input logic [31:0] sv);
        if (rst) begin
            m_run = 1'b0; m_q = '0; m_qv = 1'b0; m_p = 1;
        end else begin
            m_qv = 1'b0;
            if (!m_run) begin
                if (l && !st) begin
                    m_p = clamp(d); m_run = 1'b1; m_next = ecnt + 1;
                end
            end else if (st) begin
                m_run = 1'b0;
            end else if (l) begin
                m_p = clamp(d); m_next = ecnt + 1;
            end else if (ecnt == m_next) begin
                m_q = sv; m_qv = 1'b1; m_next = ecnt + m_p;
            end
        end
    endtask

    // One clock: drive at negedge, advance the model at the edge, return 1 ns later.
    task automatic step(input bit rst, input bit l, input bit st, input int d, input logic [31:0] sv);
        @(negedge aclk);
        areset = rst; ld = l; stop = st; div = CNT_W'(d); s = sv;
        @(posedge aclk);
        ecnt++;
        model_edge(rst, l, st, d, sv);
        #1;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge aclk) begin
        if (chk_en) begin
            chk("cyc_q", q, m_q);
            chk("cyc_qv", {31'd0, q_valid}, {31'd0, m_qv});
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_run});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int caps[$];

        // Reset and reset-state check
        step(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_q", q, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Divide-by-4, s = edge index: captures at 2, 6, 10, 14
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            step(0, k == 1, 0, 4, 32'(k));
            if (k == 2 || k == 6 || k == 10 || k == 14) begin
                chk("div4_q", q, 32'(k));
                chk("div4_qv", {31'd0, q_valid}, 32'd1);
                chk("div4_model_q", m_q, 32'(k));
            end else begin
                chk("div4_qv0", {31'd0, q_valid}, 32'd0);
            end
        end

        // Reset mid-run with q = DEADBEEF
        step(0, 1, 0, 1, 32'hDEADBEEF);
        step(0, 0, 0, 1, 32'hDEADBEEF);
        chk("pre_rst_q", q, 32'hDEADBEEF);
        step(1, 0, 0, 0, 32'h1234);
        chk("midrst_q", q, 32'h0);
        chk("midrst_qv", {31'd0, q_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        step(1, 0, 0, 0, 32'h1234);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 5, 32'h5555);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_q", q, 32'h0);
        end

        // Clamp div=0 -> every cycle, q follows s
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 32'h77);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 9, 32'(k * 7));
            chk("p1_qv", {31'd0, q_valid}, 32'd1);
            chk("p1_q", q, 32'(k * 7));
        end

        // Clamp div=31 -> 16-cycle spacing, first capture 2nd edge after ld
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            step(0, k == 1, 0, 31, 32'(k));
            if (q_valid) caps.push_back(k);
        end
        chk("p16_ncap", 32'(caps.size()), 32'd3);
        if (caps.size() >= 2) begin
            chk("p16_first", 32'(caps[0]), 32'd2);
            chk("p16_gap", 32'(caps[1] - caps[0]), 32'd16);
        end

        // Stop and restart
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            step(0, k == 1 || k == 13, k == 8, (k == 13) ? 2 : 3, 32'(100 + k));
            if (k == 5)  chk("stop_q5", q, 32'd105);
            if (k == 8)  chk("stop_busy", {31'd0, busy}, 32'd0);
            if (k == 8)  chk("stop_noqv", {31'd0, q_valid}, 32'd0);
            if (k == 12) chk("stop_hold", q, 32'd105);
            if (k == 14) chk("restart_q14", q, 32'd114);
            if (k == 15) chk("restart_qv15", {31'd0, q_valid}, 32'd0);
            if (k == 16) chk("restart_q16", q, 32'd116);
            if (k == 16) chk("restart_qv16", {31'd0, q_valid}, 32'd1);
        end

        // Restart mid-hold: P=8, ld div=2 three cycles after the capture
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, k == 1 || k == 5, 0, (k == 5) ? 2 : 8, 32'(200 + k));
            if (k == 4) chk("mh_hold", q, 32'd202);
            if (k == 6) chk("mh_q6", q, 32'd206);
            if (k == 7) chk("mh_qv7", {31'd0, q_valid}, 32'd0);
            if (k == 8) chk("mh_q8", q, 32'd208);
        end

        // ld + stop together during HOLD
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, k == 1 || k == 3 || k == 7, k == 3, (k == 3) ? 5 : ((k == 7) ? 0 : 3), 32'(300 + k));
            if (k == 3 || k == 6) chk("ldstop_busy", {31'd0, busy}, 32'd0);
            if (k == 6) chk("ldstop_q", q, 32'd302);
            if (k >= 8) chk("ldstop_p1_q", q, 32'(300 + k));
        end

        // Randomized run
        for (int k = 0; k < 4000; k++) begin
            step($urandom_range(199) == 0, $urandom_range(9) == 0, $urandom_range(29) == 0,
                 int'($urandom_range(31)), $urandom);
        end

        @(negedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ff_div_n.md
Name: ff_div_n

Overview:
- Parametrised sample-and-hold rate divider for the accelerator datapath.
- After a load request it captures the input word `s` once every P clock cycles and holds it on `q` between captures.
- P is programmable at run time, and each capture is flagged with a one-cycle strobe so downstream stages know when a fresh value has arrived.
- Successor to the fixed divide-by-4 holder: it adds width and period parameters, run-time ratio, stop/restart control, a valid strobe and a synchronous reset.

Parameters:
- WIDTH, 32, data width of `s` and `q`.
- DIV_MAX, 16, largest supported hold period P (must be >= 1).
- CNT_W, $clog2(DIV_MAX+1), counter/ratio width (derived; do not override).

Ports:
- aclk  in  1  clock; all logic on its rising edge.
- areset  in  1  synchronous, active-high reset.
- ld  in  1  start/restart request; latches `div`.
- stop  in  1  return to IDLE while keeping the last `q`.
- div  in  CNT_W  requested period P, sampled only when `ld` is high.
- s  in  WIDTH  data to sample.
- q  out  WIDTH  held sample (registered).
- q_valid  out  1  one-cycle pulse, high in the cycle after each capture edge.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (areset high at an edge): state=IDLE, q=0, q_valid=0, cnt=0, div_r=1, busy=0. Reset has priority over every other input, including mid-hold.
- div_r latching rule: on any accepted `ld`, div_r <= clamp(div):
  - 0 -> 1
  - greater than DIV_MAX -> DIV_MAX
  - otherwise unchanged.
- q_valid default: 0 at every edge unless an edge sets it.
- IDLE state:
  - q holds its value; busy=0.
  - ld=1 (and stop=0): latch div_r per the rule above, next state SAMPLE.
- SAMPLE state (exactly one cycle):
  - At the edge: q <= s, q_valid <= 1, cnt <= div_r-1.
  - Next state HOLD if div_r >= 2; stays SAMPLE if div_r = 1 (capture every cycle).
- HOLD state:
  - At each edge: cnt <= cnt-1. When cnt = 1 at the edge, next state SAMPLE.
  - q is unchanged throughout HOLD.
- Resulting timing:
  - Capture edges are exactly P cycles apart.
  - The first capture happens on the 2nd edge after `ld` is seen in IDLE.
  - q_valid is high P-periodically, one cycle wide; it is continuously high when P = 1.
- stop (non-IDLE state, no reset): next state IDLE.
  - q keeps its last captured value (it is not zeroed).
  - No capture occurs on that edge, even if the state was SAMPLE.
- ld while busy (stop=0): re-latch div_r, next state SAMPLE.
  - The current hold is aborted.
  - The capture at the following edge uses the new ratio.
- ld and stop together: stop wins; div_r is not updated.
- `div` changes without `ld`: ignored.
- `s` is sampled only at SAMPLE edges; changes during HOLD never reach q.

Test Plan:
- Reset check: assert areset 2 cycles mid-run with q=0xDEADBEEF -> q=0, q_valid=0, busy=0 on the first edge after reset; IDLE thereafter with ld=0.
- Divide-by-4: ld=1 with div=4 for one cycle at edge 0; s = cycle index -> captures at edges 2, 6, 10, 14; q = 0x2, 0x6, 0xA, 0xE; q_valid pulses only in the cycles after those edges.
- Clamping: div=0 -> q_valid high every cycle and q follows s delayed by one cycle; div=31 with DIV_MAX=16 -> captures 16 cycles apart.
- Stop and restart: run P=3, stop at edge 7 -> busy falls, q holds the edge-5 sample indefinitely; ld with div=2 at edge 12 -> captures at edges 14, 16.
- Restart mid-hold: P=8 running, ld with div=2 asserted 3 cycles after a capture -> the next capture is 2 edges after the ld edge, then every 2 cycles.
- Simultaneous ld+stop during HOLD with div=5 (old P=3) -> IDLE, div_r stays 3; a later ld with div=0 gives P=1.
